// File: rtl/hdmi_audio_fifo.sv
// hdmi_audio_fifo: stereo PCM circular buffer feeding the HDMI stage, one pair per strobe.
module hdmi_audio_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter UNDERFLOW_MODE = "HOLD"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [15:0]           in_left,
  input  logic [15:0]           in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  audio_sample_strobe,
  output logic [15:0]           audio_sample_left,
  output logic [15:0]           audio_sample_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam bit ZERO_FILL = (UNDERFLOW_MODE == "ZERO");
  logic [31:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic [31:0] out_q, out_d;
  logic uf_q, uf_d;
  logic [15:0] cnt_q, cnt_d;
  logic push, pop, empty;
  // Ready is held low during reset and flush so nothing is accepted into state being cleared.
  assign empty = level_q == '0;
  assign in_ready = !rst && !flush && level_q != LVL_FULL;
  assign push = in_valid && in_ready;
  assign pop = audio_sample_strobe && !empty;
  always_comb begin
    wr_d = flush ? '0 : push ? wr_q + PTR_ONE : wr_q;
    rd_d = flush ? '0 : pop ? rd_q + PTR_ONE : rd_q;
    level_d = flush ? '0 : (push && !pop) ? level_q + LVL_ONE : (pop && !push) ? level_q - LVL_ONE : level_q;
    uf_d = !flush && audio_sample_strobe && empty;
    cnt_d = (uf_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    out_d = flush ? '0 : pop ? mem_q[rd_q] : (uf_d && ZERO_FILL) ? '0 : out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      out_q <= '0;
      uf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      out_q <= out_d;
      uf_q <= uf_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_left, in_right};
  assign audio_sample_left = out_q[31:16];
  assign audio_sample_right = out_q[15:0];
  assign level = level_q;
  assign underflow = uf_q;
  assign underflow_count = cnt_q;
endmodule

// File: tb/tb_hdmi_audio_fifo.sv
// tb_hdmi_audio_fifo: three instances (depth 16 HOLD, depth 4 HOLD, depth 16 ZERO) against a queue model.
module tb_hdmi_audio_fifo;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, strobe = 0;
  logic [15:0] in_left = 0, in_right = 0;
  always #5 clk = ~clk;
  logic rdy [3];
  logic ufl [3];
  logic [15:0] al [3], ar [3], cnt [3];
  logic [8:0] lvl [3];
  logic [4:0] lv0, lv2;
  logic [2:0] lv1;
  assign lvl[0] = {4'd0, lv0};
  assign lvl[1] = {6'd0, lv1};
  assign lvl[2] = {4'd0, lv2};
  hdmi_audio_fifo #(.DEPTH_LOG2(4), .UNDERFLOW_MODE("HOLD")) u0 (.clk(clk), .rst(rst), .flush(flush),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(rdy[0]),
    .audio_sample_strobe(strobe), .audio_sample_left(al[0]), .audio_sample_right(ar[0]),
    .level(lv0), .underflow(ufl[0]), .underflow_count(cnt[0]));
  hdmi_audio_fifo #(.DEPTH_LOG2(2), .UNDERFLOW_MODE("HOLD")) u1 (.clk(clk), .rst(rst), .flush(flush),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(rdy[1]),
    .audio_sample_strobe(strobe), .audio_sample_left(al[1]), .audio_sample_right(ar[1]),
    .level(lv1), .underflow(ufl[1]), .underflow_count(cnt[1]));
  hdmi_audio_fifo #(.DEPTH_LOG2(4), .UNDERFLOW_MODE("ZERO")) u2 (.clk(clk), .rst(rst), .flush(flush),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(rdy[2]),
    .audio_sample_strobe(strobe), .audio_sample_left(al[2]), .audio_sample_right(ar[2]),
    .level(lv2), .underflow(ufl[2]), .underflow_count(cnt[2]));
  logic [31:0] mq [3][$];
  logic [31:0] mout [3];
  logic muf [3];
  logic [15:0] mcnt [3];
  int cap [3] = '{16, 4, 16};
  bit zm [3] = '{0, 0, 1};
  int errs = 0, checks = 0;
  function automatic logic exp_rdy(int i);
    return !rst && !flush && mq[i].size() < cap[i];
  endfunction
  task automatic cycle();
    for (int i = 0; i < 3; i++) begin
      logic r;
      r = exp_rdy(i);
      if (rst) begin
        mq[i].delete(); mout[i] = '0; muf[i] = 0; mcnt[i] = '0;
      end else if (flush) begin
        mq[i].delete(); mout[i] = '0; muf[i] = 0;
      end else begin
        muf[i] = 0;
        if (strobe) begin
          if (mq[i].size() > 0) mout[i] = mq[i].pop_front();
          else begin
            muf[i] = 1;
            if (mcnt[i] != 16'hFFFF) mcnt[i] = mcnt[i] + 16'd1;
            if (zm[i]) mout[i] = '0;
          end
        end
        if (in_valid && r) mq[i].push_back({in_left, in_right});
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 1; strobe = 1; in_left = 16'h5555; in_right = 16'hAAAA;
    cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({al[i], ar[i]} !== 32'd0) begin errs++; $display("FAIL rst_out dut%0d: got %h want 0", i, {al[i], ar[i]}); end
      checks++; if (rdy[i] !== 1'b0) begin errs++; $display("FAIL rst_ready dut%0d: got %b want 0", i, rdy[i]); end
      checks++; if (lvl[i] !== 9'd0) begin errs++; $display("FAIL rst_level dut%0d: got %0d want 0", i, lvl[i]); end
      checks++; if (ufl[i] !== 1'b0 || cnt[i] !== 16'd0) begin errs++; $display("FAIL rst_uf dut%0d: got %b/%0d want 0/0", i, ufl[i], cnt[i]); end
    end
    in_valid = 0; strobe = 0; rst = 0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdy[i] !== 1'b1) begin errs++; $display("FAIL rst_release_ready dut%0d: got %b want 1", i, rdy[i]); end
    end
    cycle();
  endtask
  task automatic test_ordered();
    logic [15:0] el [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [15:0] er [3] = '{16'hA001, 16'hA002, 16'hA003};
    for (int k = 0; k < 3; k++) begin
      in_left = el[k]; in_right = er[k]; in_valid = 1; cycle();
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (lvl[i] !== 9'd3 || {al[i], ar[i]} !== 32'd0) begin errs++; $display("FAIL ord_fill dut%0d: got lvl %0d out %h want 3/0", i, lvl[i], {al[i], ar[i]}); end
    end
    for (int s = 0; s < 3; s++) begin
      strobe = 1; cycle(); strobe = 0;
      for (int i = 0; i < 3; i++) begin
        checks++; if ({al[i], ar[i]} !== {el[s], er[s]}) begin errs++; $display("FAIL ord_out s%0d dut%0d: got %h want %h", s, i, {al[i], ar[i]}, {el[s], er[s]}); end
        checks++; if (lvl[i] !== 9'(2 - s) || ufl[i] !== 1'b0) begin errs++; $display("FAIL ord_lvl s%0d dut%0d: got %0d/%b want %0d/0", s, i, lvl[i], ufl[i], 2 - s); end
      end
      repeat (9) begin
        cycle();
        checks++; if ({al[0], ar[0]} !== {el[s], er[s]}) begin errs++; $display("FAIL ord_hold s%0d: got %h want %h", s, {al[0], ar[0]}, {el[s], er[s]}); end
      end
    end
  endtask
  task automatic test_full_wrap();
    logic [15:0] v = 16'd1;
    logic acc;
    in_left = v; in_right = ~v; in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      acc = exp_rdy(1);
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++; if (rdy[i] !== exp_rdy(i) || lvl[i] !== 9'(mq[i].size())) begin errs++; $display("FAIL fill dut%0d k%0d: got rdy %b lvl %0d want %b/%0d", i, k, rdy[i], lvl[i], exp_rdy(i), mq[i].size()); end
      end
      if (acc) begin v = v + 16'd1; in_left = v; in_right = ~v; end
    end
    checks++; if (lvl[1] !== 9'd4 || rdy[1] !== 1'b0) begin errs++; $display("FAIL full_d4: got lvl %0d rdy %b want 4/0", lvl[1], rdy[1]); end
    strobe = 1; cycle(); strobe = 0;
    checks++; if (rdy[1] !== 1'b1 || lvl[1] !== 9'd3) begin errs++; $display("FAIL full_pop: got rdy %b lvl %0d want 1/3", rdy[1], lvl[1]); end
    checks++; if ({al[1], ar[1]} !== {16'd1, 16'hFFFE}) begin errs++; $display("FAIL full_first: got %h want 0001fffe", {al[1], ar[1]}); end
    cycle(); in_valid = 0;
    checks++; if (lvl[1] !== 9'd4) begin errs++; $display("FAIL full_fifth: got %0d want 4", lvl[1]); end
    strobe = 1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++; if ({al[i], ar[i]} !== mout[i] || ufl[i] !== muf[i]) begin errs++; $display("FAIL drain dut%0d k%0d: got %h/%b want %h/%b", i, k, {al[i], ar[i]}, ufl[i], mout[i], muf[i]); end
      end
      if (k == 3) begin
        checks++; if ({al[1], ar[1]} !== {16'd5, 16'hFFFA}) begin errs++; $display("FAIL wrap_fifth: got %h want 0005fffa", {al[1], ar[1]}); end
      end
    end
    strobe = 0; cycle();
  endtask
  task automatic test_underflow();
    logic [15:0] pre [3];
    flush = 1; cycle(); flush = 0;
    in_left = 16'h7FFF; in_right = 16'h8000; in_valid = 1; cycle(); in_valid = 0;
    strobe = 1; cycle(); strobe = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({al[i], ar[i]} !== 32'h7FFF8000) begin errs++; $display("FAIL uf_setup dut%0d: got %h want 7fff8000", i, {al[i], ar[i]}); end
      pre[i] = mcnt[i];
    end
    strobe = 1; cycle(); strobe = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ufl[i] !== 1'b1 || cnt[i] !== pre[i] + 16'd1) begin errs++; $display("FAIL uf_pulse dut%0d: got %b/%0d want 1/%0d", i, ufl[i], cnt[i], pre[i] + 16'd1); end
      checks++; if ({al[i], ar[i]} !== (zm[i] ? 32'd0 : 32'h7FFF8000)) begin errs++; $display("FAIL uf_out dut%0d: got %h want %h", i, {al[i], ar[i]}, zm[i] ? 32'd0 : 32'h7FFF8000); end
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ufl[i] !== 1'b0) begin errs++; $display("FAIL uf_one_cycle dut%0d: got %b want 0", i, ufl[i]); end
    end
  endtask
  task automatic test_simul();
    in_left = 16'hABCD; in_right = 16'h1234; in_valid = 1; strobe = 1; cycle();
    in_valid = 0; strobe = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ufl[i] !== 1'b1 || lvl[i] !== 9'd1) begin errs++; $display("FAIL simul_uf dut%0d: got %b/%0d want 1/1", i, ufl[i], lvl[i]); end
    end
    strobe = 1; cycle(); strobe = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({al[i], ar[i]} !== 32'hABCD1234 || ufl[i] !== 1'b0 || lvl[i] !== 9'd0) begin errs++; $display("FAIL simul_pop dut%0d: got %h/%b/%0d want abcd1234/0/0", i, {al[i], ar[i]}, ufl[i], lvl[i]); end
    end
  endtask
  task automatic test_flush();
    logic [15:0] pre [3];
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin in_left = 16'($urandom); in_right = 16'($urandom); cycle(); end
    in_valid = 0;
    strobe = 1; cycle(); strobe = 0;
    in_valid = 1; cycle(); in_valid = 0;
    for (int i = 0; i < 3; i++) pre[i] = mcnt[i];
    flush = 1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (lvl[i] !== 9'd3 || rdy[i] !== 1'b0) begin errs++; $display("FAIL flush_pre dut%0d: got lvl %0d rdy %b want 3/0", i, lvl[i], rdy[i]); end
    end
    cycle(); flush = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (lvl[i] !== 9'd0 || {al[i], ar[i]} !== 32'd0 || cnt[i] !== pre[i]) begin errs++; $display("FAIL flush_clr dut%0d: got %0d/%h/%0d want 0/0/%0d", i, lvl[i], {al[i], ar[i]}, cnt[i], pre[i]); end
    end
    strobe = 1; cycle(); strobe = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ufl[i] !== 1'b1 || cnt[i] !== pre[i] + 16'd1) begin errs++; $display("FAIL flush_uf dut%0d: got %b/%0d want 1/%0d", i, ufl[i], cnt[i], pre[i] + 16'd1); end
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      in_valid = $urandom_range(0, 9) < 7;
      strobe = $urandom_range(0, 9) < 3;
      flush = $urandom_range(0, 49) == 0;
      in_left = 16'($urandom); in_right = 16'($urandom);
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++; if ({al[i], ar[i]} !== mout[i]) begin errs++; $display("FAIL rnd_out dut%0d k%0d: got %h want %h", i, k, {al[i], ar[i]}, mout[i]); end
        checks++; if (lvl[i] !== 9'(mq[i].size())) begin errs++; $display("FAIL rnd_lvl dut%0d k%0d: got %0d want %0d", i, k, lvl[i], mq[i].size()); end
        checks++; if (rdy[i] !== exp_rdy(i)) begin errs++; $display("FAIL rnd_rdy dut%0d k%0d: got %b want %b", i, k, rdy[i], exp_rdy(i)); end
        checks++; if (ufl[i] !== muf[i] || cnt[i] !== mcnt[i]) begin errs++; $display("FAIL rnd_uf dut%0d k%0d: got %b/%0d want %b/%0d", i, k, ufl[i], cnt[i], muf[i], mcnt[i]); end
      end
    end
    in_valid = 0; strobe = 0; flush = 0;
  endtask
  task automatic test_saturate_async();
    flush = 1; cycle(); flush = 0;
    strobe = 1;
    repeat (65540) cycle();
    strobe = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cnt[i] !== 16'hFFFF || cnt[i] !== mcnt[i]) begin errs++; $display("FAIL sat_count dut%0d: got %h want ffff", i, cnt[i]); end
      checks++; if (ufl[i] !== 1'b1) begin errs++; $display("FAIL sat_uf dut%0d: got %b want 1", i, ufl[i]); end
    end
    in_valid = 1; in_left = 16'h0F0F; in_right = 16'hF0F0; cycle();
    @(negedge clk); #2;
    rst = 1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({al[i], ar[i]} !== 32'd0 || lvl[i] !== 9'd0 || ufl[i] !== 1'b0 || cnt[i] !== 16'd0 || rdy[i] !== 1'b0) begin
        errs++; $display("FAIL async_rst dut%0d: got out %h lvl %0d uf %b cnt %0d rdy %b want all 0", i, {al[i], ar[i]}, lvl[i], ufl[i], cnt[i], rdy[i]);
      end
    end
    in_valid = 0; cycle(); rst = 0; cycle();
  endtask
  initial begin
    test_reset();
    test_ordered();
    test_full_wrap();
    test_underflow();
    test_simul();
    test_flush();
    test_random();
    test_saturate_async();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
